// File: rtl/dsp_slice_pkg.sv
// Shared definitions for the DSP slice MAC pipeline: mode encoding and the S1 stage record.
// Operand fields are sized for the widest supported DWIDTH (< DSP_OP_MAX) and zero-extended on capture.
package dsp_slice_pkg;

   localparam int DSP_OP_MAX = 32;

   typedef logic [1:0] dsp_mode_t;

   localparam dsp_mode_t DSP_MODE_ADD = 2'b00;
   localparam dsp_mode_t DSP_MODE_MUL = 2'b01;
   localparam dsp_mode_t DSP_MODE_MAC = 2'b10;
   localparam dsp_mode_t DSP_MODE_FMA = 2'b11;

   typedef struct packed {
      logic                  valid;
      dsp_mode_t             mode;
      logic [DSP_OP_MAX-1:0] ax;
      logic [DSP_OP_MAX-1:0] ay;
      logic [DSP_OP_MAX-1:0] az;
   } dsp_stage_t;

endpackage

// File: rtl/dsp_sat_downcast.sv
// Combinational ACC_WIDTH -> DWIDTH downcast. With DSP_SLICE_SAT_EN defined, out-of-range values
// clamp to the signed limits and raise overflow; otherwise the low bits wrap and overflow stays 0.
module dsp_sat_downcast
   import dsp_slice_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int ACC_WIDTH = 24
) (
   input  logic [ACC_WIDTH-1:0] sum,
   output logic [DWIDTH-1:0]    result,
   output logic                 overflow
);

`ifdef DSP_SLICE_SAT_EN
   logic fits;

   // In range exactly when every bit above the result sign bit repeats it.
   assign fits = (sum[ACC_WIDTH-1:DWIDTH-1] == '0) || (sum[ACC_WIDTH-1:DWIDTH-1] == '1);

   always_comb begin
      result   = sum[DWIDTH-1:0];
      overflow = 1'b0;
      if (!fits) begin
         overflow = 1'b1;
         result   = sum[ACC_WIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
      end
   end
`else
   logic unused_hi;

   assign unused_hi = ^sum[ACC_WIDTH-1:DWIDTH];
   assign result    = sum[DWIDTH-1:0];
   assign overflow  = 1'b0;
`endif

endmodule

// File: rtl/dsp_slice_mac_pipe.sv
// Signed ADD/MUL/FMA/grouped-MAC slice, 3 register stages; result seen at the 3rd edge after accept.
// One global advance (in_ready = ~out_valid | out_ready) freezes all stages under backpressure; DSP_SLICE_SAT_EN selects saturation.
module dsp_slice_mac_pipe
   import dsp_slice_pkg::*;
#(
   parameter int DWIDTH    = 8,
   parameter int ACC_WIDTH = 24,
   parameter int LEN_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           mode,
   input  logic [LEN_WIDTH-1:0] acc_len,
   input  logic [DWIDTH-1:0]    ax,
   input  logic [DWIDTH-1:0]    ay,
   input  logic [DWIDTH-1:0]    az,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DWIDTH-1:0]    result,
   output logic                 overflow
);

   localparam int PW = 2 * DWIDTH;

   logic adv;

   dsp_stage_t           s1_q;
   logic [LEN_WIDTH-1:0] s1_len_q;

   logic                        s2_valid_q;
   dsp_mode_t                   s2_mode_q;
   logic signed [PW-1:0]        s2_term_q;
   logic signed [ACC_WIDTH-1:0] s2_ax_q;
   logic [LEN_WIDTH-1:0]        s2_len_q;

   logic signed [ACC_WIDTH-1:0] acc_q;
   logic [LEN_WIDTH-1:0]        cnt_q;
   logic [LEN_WIDTH-1:0]        len_q;
   logic                        out_valid_q;
   logic [DWIDTH-1:0]           result_q;
   logic                        overflow_q;

   assign adv       = ~out_valid_q | out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign overflow  = overflow_q;

   // ---------------- S1: operand capture ----------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_q     <= '0;
         s1_len_q <= '0;
      end else if (adv) begin
         s1_q.valid <= in_valid;
         s1_q.mode  <= mode;
         s1_q.ax    <= DSP_OP_MAX'(ax);
         s1_q.ay    <= DSP_OP_MAX'(ay);
         s1_q.az    <= DSP_OP_MAX'(az);
         s1_len_q   <= acc_len;
      end
   end

   // ---------------- S2: product / addend ----------------
   logic signed [DWIDTH-1:0] s1_ax;
   logic signed [DWIDTH-1:0] s1_ay;
   logic signed [DWIDTH-1:0] s1_az;
   logic signed [PW-1:0]     s1_prod;
   logic signed [PW-1:0]     s1_term;
   logic                     unused_op_hi;

   assign s1_ax   = s1_q.ax[DWIDTH-1:0];
   assign s1_ay   = s1_q.ay[DWIDTH-1:0];
   assign s1_az   = s1_q.az[DWIDTH-1:0];
   assign s1_prod = PW'(s1_ay) * PW'(s1_az);
   // ADD reuses the product slot to carry ay, so S3 always adds ax to one term.
   assign s1_term = (s1_q.mode == DSP_MODE_ADD) ? PW'(s1_ay) : s1_prod;
   assign unused_op_hi = ^{s1_q.ax[DSP_OP_MAX-1:DWIDTH], s1_q.ay[DSP_OP_MAX-1:DWIDTH],
                           s1_q.az[DSP_OP_MAX-1:DWIDTH]};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s2_valid_q <= 1'b0;
         s2_mode_q  <= DSP_MODE_ADD;
         s2_term_q  <= '0;
         s2_ax_q    <= '0;
         s2_len_q   <= '0;
      end else if (adv) begin
         s2_valid_q <= s1_q.valid;
         s2_mode_q  <= s1_q.mode;
         s2_term_q  <= s1_term;
         s2_ax_q    <= ACC_WIDTH'(s1_ax);
         s2_len_q   <= s1_len_q;
      end
   end

   // ---------------- S3: sum, accumulate, downcast ----------------
   logic signed [ACC_WIDTH-1:0] term_ext;
   logic signed [ACC_WIDTH-1:0] sum;
   logic [LEN_WIDTH-1:0]        cnt_inc;
   logic [LEN_WIDTH-1:0]        grp_len;
   logic                        mac_first;
   logic                        mac_last;
   logic                        emit;
   logic [DWIDTH-1:0]           dc_result;
   logic                        dc_overflow;

   assign term_ext = ACC_WIDTH'(s2_term_q);

   always_comb begin
      mac_first = (cnt_q == '0);
      grp_len   = mac_first ? ((s2_len_q == '0) ? LEN_WIDTH'(1) : s2_len_q) : len_q;
      cnt_inc   = cnt_q + LEN_WIDTH'(1);
      mac_last  = (cnt_inc == grp_len);
      sum       = term_ext;
      emit      = s2_valid_q;
      case (s2_mode_q)
         DSP_MODE_ADD, DSP_MODE_FMA: sum = s2_ax_q + term_ext;
         DSP_MODE_MUL:               sum = term_ext;
         DSP_MODE_MAC: begin
            sum  = (mac_first ? '0 : acc_q) + term_ext;
            emit = s2_valid_q & mac_last;
         end
         default: ;
      endcase
   end

   dsp_sat_downcast #(
      .DWIDTH    (DWIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_downcast (
      .sum      (sum),
      .result   (dc_result),
      .overflow (dc_overflow)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         acc_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         overflow_q  <= 1'b0;
      end else if (adv) begin
         out_valid_q <= emit;
         if (emit) begin
            result_q   <= dc_result;
            overflow_q <= dc_overflow;
         end
         if (s2_valid_q) begin
            if (s2_mode_q == DSP_MODE_MAC) begin
               acc_q <= sum;
               cnt_q <= mac_last ? '0 : cnt_inc;
               if (mac_first) len_q <= grp_len;
            end else begin
               // Any other op abandons an open group's partial sum.
               cnt_q <= '0;
            end
         end
      end
   end

   a_out_hold: assert property (@(posedge clk) disable iff (!resetn)
      (out_valid_q && !out_ready) |=> (out_valid_q && $stable(result_q) && $stable(overflow_q)));

endmodule

// File: tb/tb_dsp_slice_mac_pipe.sv
// Bench for dsp_slice_mac_pipe: directed literal cases plus randomized traffic against a queue model.
module tb_dsp_slice_mac_pipe;

   localparam int DW = 8;
   localparam int AW = 24;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    mode = 2'b00;
   logic [LW-1:0] acc_len = '0;
   logic [DW-1:0] ax = '0;
   logic [DW-1:0] ay = '0;
   logic [DW-1:0] az = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] result;
   logic          overflow;

   always #5 clk = ~clk;

   dsp_slice_mac_pipe #(.DWIDTH(DW), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .mode(mode), .acc_len(acc_len), .ax(ax), .ay(ay), .az(az),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .overflow(overflow));

   typedef struct {
      logic [DW-1:0] res;
      logic          ovf;
   } exp_t;

   exp_t   expq[$];
   bit     g_open = 1'b0;
   int     g_cnt = 0;
   int     g_len = 0;
   longint g_acc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d", name, got, want);
      end
   endtask

   // Reduce a full-precision value to the DW-bit result the slice should show.
   function automatic exp_t narrow(longint v);
      exp_t   e;
      longint span, w, hi, lo;
      span = longint'(1) << AW;
      w = v % span;
      if (w < 0) w += span;
      if (w >= span / 2) w -= span;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -(longint'(1) << (DW - 1));
      e.res = w[DW-1:0];
      e.ovf = 1'b0;
`ifdef DSP_SLICE_SAT_EN
      if (w > hi) begin e.res = DW'(hi); e.ovf = 1'b1; end
      else if (w < lo) begin e.res = DW'(lo); e.ovf = 1'b1; end
`else
      if (hi < lo) e.ovf = 1'b1;
`endif
      return e;
   endfunction

   function automatic void model_accept(logic [1:0] m, logic [DW-1:0] x, logic [DW-1:0] y,
                                        logic [DW-1:0] z, logic [LW-1:0] len);
      longint sx, sy, sz;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sz = longint'($signed(z));
      if (m == 2'b10) begin
         if (!g_open) begin
            g_open = 1'b1;
            g_cnt  = 0;
            g_acc  = 0;
            g_len  = (len == 0) ? 1 : int'(len);
         end
         g_acc += sy * sz;
         g_cnt++;
         if (g_cnt == g_len) begin
            expq.push_back(narrow(g_acc));
            g_open = 1'b0;
         end
      end else begin
         g_open = 1'b0;
         case (m)
            2'b00:   expq.push_back(narrow(sx + sy));
            2'b01:   expq.push_back(narrow(sy * sz));
            default: expq.push_back(narrow(sx + sy * sz));
         endcase
      end
   endfunction

   // Inputs settle 1ns after each rising edge, so the falling edge sees what the next rising edge will take.
   always @(negedge clk) begin
      if (!resetn) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 1);
         chk("rst_result", result, 0);
         chk("rst_overflow", overflow, 0);
         expq.delete();
         g_open = 1'b0;
      end else begin
         chk("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (out_valid) begin
            if (expq.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL spurious_out: result=%0d with out_valid=1, required no output", result);
            end else begin
               chk("stream_result", result, expq[0].res);
               chk("stream_overflow", overflow, expq[0].ovf);
               if (out_ready) void'(expq.pop_front());
            end
         end
         if (in_valid && in_ready) model_accept(mode, ax, ay, az, acc_len);
      end
   end

   task automatic send(input logic [1:0] m, input int x, input int y, input int z, input int len);
      in_valid = 1'b1;
      mode     = m;
      ax       = DW'(x);
      ay       = DW'(y);
      az       = DW'(z);
      acc_len  = LW'(len);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Called just after the accepting edge; the result must be visible before the third edge.
   task automatic expect3(input string name, input logic [DW-1:0] r, input logic o);
      chk({name, "_lat0"}, out_valid, 0);
      @(posedge clk); #1;
      chk({name, "_lat1"}, out_valid, 0);
      @(posedge clk); #1;
      chk({name, "_valid"}, out_valid, 1);
      chk({name, "_result"}, result, r);
      chk({name, "_ovf"}, overflow, o);
   endtask

   task automatic idle_check(input string name, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         chk(name, out_valid, 0);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      resetn = 1'b1;
      chk("post_reset_in_ready", in_ready, 1);
      @(posedge clk); #1;

`ifdef DSP_SLICE_SAT_EN
      send(2'b01, 0, 100, 100, 0);    expect3("mul_big", 8'd127, 1'b1);
      idle_check("gap", 2);
      send(2'b00, -100, -100, 0, 0);  expect3("add_neg", 8'h80, 1'b1);
`else
      send(2'b01, 0, 100, 100, 0);    expect3("mul_big", 8'd16, 1'b0);
      idle_check("gap", 2);
      send(2'b00, -100, -100, 0, 0);  expect3("add_neg", 8'd56, 1'b0);
`endif
      idle_check("gap", 2);

      send(2'b11, 10, -2, 7, 0);
      send(2'b01, 0, 3, 4, 0);
      chk("fma_lat1", out_valid, 0);
      @(posedge clk); #1;
      chk("fma_result", result, 8'hFC);
      chk("fma_valid", out_valid, 1);
      chk("fma_ovf", overflow, 0);
      @(posedge clk); #1;
      chk("mul_b2b_result", result, 8'd12);
      chk("mul_b2b_valid", out_valid, 1);
      idle_check("gap", 2);

      // Later beats carry a different acc_len; the group length must stay 4.
      send(2'b10, 0, 3, 5, 4);  chk("mac_beat1", out_valid, 0);
      send(2'b10, 0, 3, 5, 1);  chk("mac_beat2", out_valid, 0);
      send(2'b10, 0, 3, 5, 1);  chk("mac_beat3", out_valid, 0);
      send(2'b10, 0, 3, 5, 2);  expect3("mac4", 8'd60, 1'b0);
      idle_check("mac4_single", 1);
      send(2'b10, 0, 2, 2, 0);  expect3("mac_len0", 8'd4, 1'b0);
      idle_check("gap", 2);

      send(2'b00, 1, 1, 0, 0);
      send(2'b00, 2, 2, 0, 0);
      send(2'b00, 3, 3, 0, 0);
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_in_ready", in_ready, 0);
         chk("bp_valid", out_valid, 1);
         chk("bp_result", result, 8'd2);
      end
      out_ready = 1'b1;
      @(posedge clk); #1; chk("bp_rel_4", result, 8'd4); chk("bp_rel_4v", out_valid, 1);
      @(posedge clk); #1; chk("bp_rel_6", result, 8'd6); chk("bp_rel_6v", out_valid, 1);
      @(posedge clk); #1; chk("bp_drained", out_valid, 0);

      send(2'b10, 0, 1, 1, 4);
      send(2'b10, 0, 1, 1, 4);
      resetn = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      @(posedge clk); #1;
      resetn = 1'b1;
      idle_check("midrst_no_partial", 4);
      send(2'b10, 0, 1, 1, 2);
      send(2'b10, 0, 1, 1, 2);  expect3("postrst_mac2", 8'd2, 1'b0);
      idle_check("gap", 2);

      send(2'b10, 0, 5, 5, 4);
      send(2'b10, 0, 5, 5, 4);
      send(2'b01, 0, 3, 3, 0);  expect3("mul_breaks_group", 8'd9, 1'b0);
      idle_check("group_discarded", 4);
      send(2'b10, 0, 2, 3, 2);
      send(2'b10, 0, 2, 3, 2);  expect3("fresh_group", 8'd12, 1'b0);
      idle_check("gap", 2);

      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         mode      = 2'($urandom_range(0, 3));
         ax        = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 6) - 3);
         ay        = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 6) - 3);
         az        = $urandom_range(0, 1) ? DW'($urandom) : DW'($urandom_range(0, 6) - 3);
         acc_len   = LW'($urandom_range(0, 5));
         out_ready = ($urandom_range(0, 9) < 7);
         resetn    = ($urandom_range(0, 399) != 0);
         @(posedge clk); #1;
      end

      in_valid  = 1'b0;
      out_ready = 1'b1;
      resetn    = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk("drain_empty", expq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
